// File: rtl/mem_arbiter.sv
// Two-client memory arbiter merging the icache and dcache memory-side ports onto one port.
// Grants one whole line transaction at a time and routes read beats back to the owner.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS = 26,
  parameter int unsigned DATA_BITS = 128,
  parameter int unsigned BEATS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_req_val,
  output logic                   ic_req_rdy,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_val,
  output logic [DATA_BITS-1:0]   ic_resp_data,

  input  logic                   dc_req_val,
  output logic                   dc_req_rdy,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_val,
  output logic [DATA_BITS-1:0]   dc_resp_data,

  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_val,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int unsigned CntBits = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntBits-1:0] LastBeat = CntBits'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StWdata, StRresp} state_e;

  state_e             state_q;
  logic               owner_q;
  logic               last_grant_q;
  logic [CntBits-1:0] beat_cnt_q;

  logic sel;
  logic in_idle, in_wdata, in_rresp;
  logic req_fire, wbeat_fire, rbeat_fire;

  // Every valid/ready output is gated by reset through these phase qualifiers.
  assign in_idle  = reset & (state_q == StIdle);
  assign in_wdata = reset & (state_q == StWdata);
  assign in_rresp = reset & (state_q == StRresp);

  // Tie goes to the client that did not win last time; 1 selects dc.
  assign sel = (ic_req_val & dc_req_val) ? ~last_grant_q : dc_req_val;

  assign mem_req_val  = in_idle & (sel ? dc_req_val : ic_req_val);
  assign mem_req_addr = sel ? dc_req_addr : ic_req_addr;
  assign mem_req_rw   = reset & (sel ? dc_req_rw : ic_req_rw);
  assign ic_req_rdy   = in_idle & ~sel & mem_req_rdy;
  assign dc_req_rdy   = in_idle & sel & mem_req_rdy;

  assign mem_req_data_valid = in_wdata & (owner_q ? dc_req_data_valid : ic_req_data_valid);
  assign mem_req_data_bits  = owner_q ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask  = owner_q ? dc_req_data_mask : ic_req_data_mask;
  assign ic_req_data_ready  = in_wdata & ~owner_q & mem_req_data_ready;
  assign dc_req_data_ready  = in_wdata & owner_q & mem_req_data_ready;

  assign ic_resp_val  = in_rresp & ~owner_q & mem_resp_val;
  assign dc_resp_val  = in_rresp & owner_q & mem_resp_val;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;

  assign req_fire   = mem_req_val & mem_req_rdy;
  assign wbeat_fire = mem_req_data_valid & mem_req_data_ready;
  assign rbeat_fire = in_rresp & mem_resp_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            owner_q      <= sel;
            last_grant_q <= sel;
            beat_cnt_q   <= '0;
            state_q      <= mem_req_rw ? StWdata : StRresp;
          end
        end
        StWdata: begin
          if (wbeat_fire) begin
            if (beat_cnt_q == LastBeat) begin
              state_q <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + CntBits'(1);
            end
          end
        end
        StRresp: begin
          if (rbeat_fire) begin
            if (beat_cnt_q == LastBeat) begin
              state_q <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + CntBits'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized clients and memory, transaction-level
// scoreboard with a separate negedge monitor.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  // Index 0 = icache, 1 = dcache.
  logic [1:0]        rv, req_rw, dv;
  logic [1:0][25:0]  req_addr;
  logic [1:0][127:0] req_data;
  logic [1:0][15:0]  req_mask;
  wire  [1:0]        rdy, drdy, rsp;
  wire  [1:0][127:0] resp_data;

  wire         mem_req_val, mem_req_rw, mem_req_data_valid;
  wire  [25:0] mem_req_addr;
  wire [127:0] mem_req_data_bits;
  wire  [15:0] mem_req_data_mask;
  logic        mem_req_rdy, mem_req_data_ready, mem_resp_val;
  logic [127:0] mem_resp_data;

  mem_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .ic_req_val         (rv[0]),
    .ic_req_rdy         (rdy[0]),
    .ic_req_addr        (req_addr[0]),
    .ic_req_rw          (req_rw[0]),
    .ic_req_data_valid  (dv[0]),
    .ic_req_data_ready  (drdy[0]),
    .ic_req_data_bits   (req_data[0]),
    .ic_req_data_mask   (req_mask[0]),
    .ic_resp_val        (rsp[0]),
    .ic_resp_data       (resp_data[0]),
    .dc_req_val         (rv[1]),
    .dc_req_rdy         (rdy[1]),
    .dc_req_addr        (req_addr[1]),
    .dc_req_rw          (req_rw[1]),
    .dc_req_data_valid  (dv[1]),
    .dc_req_data_ready  (drdy[1]),
    .dc_req_data_bits   (req_data[1]),
    .dc_req_data_mask   (req_mask[1]),
    .dc_resp_val        (rsp[1]),
    .dc_resp_data       (resp_data[1]),
    .mem_req_val        (mem_req_val),
    .mem_req_rdy        (mem_req_rdy),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rw         (mem_req_rw),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_val       (mem_resp_val),
    .mem_resp_data      (mem_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard queues: pushed by stimulus at request acceptance, popped by the monitor.
  logic [127:0] rq[2][$];
  logic [127:0] wq_d[$];
  logic [15:0]  wq_m[$];

  int checks   = 0;
  int failures = 0;
  logic end_req  = 1'b0;
  logic mon_done = 1'b0;
  logic stim_idle = 1'b0;

  // Memory content seen by reads: a fixed function of line address and beat index.
  function automatic logic [127:0] rdata(input logic [25:0] a, input int i);
    return {6'd0, a, 32'(i), 32'hC0DE_0000 ^ 32'(a), 32'(a) * 32'd2654435761 + 32'(i)};
  endfunction

  // ---------------- stimulus: clients and memory ----------------
  int phase[2];   // 0 none, 1 requesting, 2 sending write beats, 3 awaiting read beats
  int wcnt[2], rcnt[2];
  logic [127:0] wb[2][4];
  logic [15:0]  cm[2];
  int rd_left, rd_i;
  logic [25:0] rd_addr;
  logic mem_real;
  int auto_pct, dv_pct, rdy_pct, drdy_pct, resp_pct, stray_pct, rdy_hold;
  int drdy_pat[$];

  task automatic issue(input int c, input logic [25:0] a, input logic w);
    phase[c]    = 1;
    req_addr[c] = a;
    req_rw[c]   = w;
    cm[c]       = 16'($urandom);
    for (int i = 0; i < 4; i++) wb[c][i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!reset) begin
      phase[0] = 0;
      phase[1] = 0;
      rd_left  = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (phase[c] == 1 && rv[c] && rdy[c]) begin
          if (req_rw[c]) begin
            phase[c] = 2;
            wcnt[c]  = 0;
            for (int i = 0; i < 4; i++) begin
              wq_d.push_back(wb[c][i]);
              wq_m.push_back(cm[c]);
            end
          end else begin
            phase[c] = 3;
            rcnt[c]  = 0;
            for (int i = 0; i < 4; i++) rq[c].push_back(rdata(req_addr[c], i));
          end
        end else if (phase[c] == 2 && dv[c] && drdy[c]) begin
          wcnt[c]++;
          if (wcnt[c] == 4) phase[c] = 0;
        end else if (phase[c] == 3 && rsp[c]) begin
          rcnt[c]++;
          if (rcnt[c] == 4) phase[c] = 0;
        end
      end
      if (mem_req_val && mem_req_rdy && !mem_req_rw) begin
        rd_left = 4;
        rd_i    = 0;
        rd_addr = mem_req_addr;
      end
      if (mem_resp_val && mem_real) begin
        rd_left--;
        rd_i++;
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (phase[c] == 0 && auto_pct > 0 && $urandom_range(99) < auto_pct)
        issue(c, 26'($urandom), (c == 0) ? ($urandom_range(3) == 0) : 1'($urandom_range(1)));
      rv[c]       = (phase[c] == 1);
      dv[c]       = (phase[c] == 2) && ($urandom_range(99) < dv_pct);
      req_data[c] = wb[c][wcnt[c] % 4];
      req_mask[c] = cm[c];
    end
    mem_req_rdy = (rdy_hold > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (rdy_hold > 0) rdy_hold--;
    if (drdy_pat.size() > 0 && (phase[0] == 2 || phase[1] == 2))
      mem_req_data_ready = 1'(drdy_pat.pop_front());
    else
      mem_req_data_ready = ($urandom_range(99) < drdy_pct);
    if (rd_left > 0 && $urandom_range(99) < resp_pct) begin
      mem_resp_val  = 1'b1;
      mem_real      = 1'b1;
      mem_resp_data = rdata(rd_addr, rd_i);
    end else if (rd_left == 0 && $urandom_range(99) < stray_pct) begin
      mem_resp_val  = 1'b1;
      mem_real      = 1'b0;
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      mem_resp_val = 1'b0;
      mem_real     = 1'b0;
    end
  endtask

  function automatic logic all_idle();
    return phase[0] == 0 && phase[1] == 0 && rd_left == 0;
  endfunction

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (all_idle()) break;
      cycle();
    end
  endtask

  initial begin : stim
    reset = 1'b0;
    rv = '0; dv = '0; req_rw = '0; req_addr = '0; req_data = '0; req_mask = '0;
    mem_req_rdy = 1'b0; mem_req_data_ready = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    mem_real = 1'b0; rd_left = 0; rd_i = 0; rd_addr = '0;
    for (int c = 0; c < 2; c++) begin
      phase[c] = 0; wcnt[c] = 0; rcnt[c] = 0; cm[c] = '0;
      for (int i = 0; i < 4; i++) wb[c][i] = '0;
    end
    auto_pct = 0; dv_pct = 100; rdy_pct = 100; drdy_pct = 100; resp_pct = 100;
    stray_pct = 0; rdy_hold = 0;
    repeat (3) cycle();
    reset = 1'b1;

    // Single dc read.
    issue(1, 26'h00A, 1'b0);
    wait_idle(40);

    // dc write with a throttled memory data channel.
    issue(1, 26'h010, 1'b1);
    for (int i = 0; i < 4; i++) wb[1][i] = 128'(17 * (i + 1));
    cm[1] = 16'hFFFF;
    drdy_pat = '{1, 0, 1, 1, 0, 1};
    drdy_pct = 0;
    wait_idle(40);
    drdy_pct = 100;

    // Stray memory responses around a write and a read.
    stray_pct = 60;
    resp_pct  = 50;
    issue(1, 26'h055, 1'b1);
    wait_idle(60);
    issue(1, 26'h077, 1'b0);
    wait_idle(60);
    stray_pct = 0;
    resp_pct  = 100;

    // Simultaneous requests right after reset, then dc re-requests.
    reset = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    issue(0, 26'h100, 1'b0);
    issue(1, 26'h200, 1'b0);
    for (int i = 0; i < 60 && phase[1] != 0; i++) cycle();
    issue(1, 26'h201, 1'b0);
    wait_idle(80);

    // Reset in the middle of a read, after its second beat.
    issue(0, 26'h300, 1'b0);
    for (int i = 0; i < 60 && !(phase[0] == 3 && rcnt[0] == 2); i++) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    issue(0, 26'h304, 1'b0);
    wait_idle(60);

    // Memory stalls the request channel for five cycles.
    rdy_hold = 5;
    issue(0, 26'h2AA_AAAA, 1'b0);
    wait_idle(60);

    // Randomized traffic.
    auto_pct = 25; dv_pct = 80; rdy_pct = 70; drdy_pct = 70; resp_pct = 70; stray_pct = 15;
    repeat (1500) cycle();
    auto_pct = 0;
    wait_idle(400);
    stim_idle = all_idle();
    @(posedge clk);
    #1;
    end_req = 1'b1;
    wait (mon_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, 128'(got), 128'(exp));
  endtask

  logic m_busy = 1'b0, m_rw = 1'b0, m_owner = 1'b0, m_last = 1'b0;
  int   m_cnt = 0;

  initial begin : monitor
    logic ew;
    forever begin
      @(negedge clk);
      if (end_req) begin
        chk1("stimulus_drained", stim_idle, 1'b1);
        chk("read_queue_ic_empty", 128'(rq[0].size()), 128'(0));
        chk("read_queue_dc_empty", 128'(rq[1].size()), 128'(0));
        chk("write_queue_empty", 128'(wq_d.size()), 128'(0));
        mon_done = 1'b1;
        break;
      end
      if (!reset) begin
        chk1("rst_ic_req_rdy", rdy[0], 1'b0);
        chk1("rst_dc_req_rdy", rdy[1], 1'b0);
        chk1("rst_ic_data_ready", drdy[0], 1'b0);
        chk1("rst_dc_data_ready", drdy[1], 1'b0);
        chk1("rst_ic_resp_val", rsp[0], 1'b0);
        chk1("rst_dc_resp_val", rsp[1], 1'b0);
        chk1("rst_mem_req_val", mem_req_val, 1'b0);
        chk1("rst_mem_data_valid", mem_req_data_valid, 1'b0);
        chk1("rst_mem_req_rw", mem_req_rw, 1'b0);
        rq[0].delete();
        rq[1].delete();
        wq_d.delete();
        wq_m.delete();
        m_busy = 1'b0;
        m_last = 1'b0;
      end else begin
        // Read response routing.
        if (m_busy && !m_rw) begin
          chk1("resp_val_owner", rsp[m_owner], mem_resp_val);
          chk1("resp_val_other", rsp[~m_owner], 1'b0);
          if (mem_resp_val) begin
            chk1("resp_expected", rq[m_owner].size() != 0, 1'b1);
            if (rq[m_owner].size() != 0) chk("resp_data", resp_data[m_owner], rq[m_owner].pop_front());
            m_cnt++;
          end
        end else begin
          chk1("no_resp_ic", rsp[0], 1'b0);
          chk1("no_resp_dc", rsp[1], 1'b0);
        end
        // Write data path.
        if (m_busy && m_rw) begin
          chk1("wdata_valid", mem_req_data_valid, dv[m_owner]);
          chk1("wdata_ready_owner", drdy[m_owner], mem_req_data_ready);
          chk1("wdata_ready_other", drdy[~m_owner], 1'b0);
          if (mem_req_data_valid && mem_req_data_ready) begin
            chk1("wbeat_expected", wq_d.size() != 0, 1'b1);
            if (wq_d.size() != 0) begin
              chk("wbeat_data", mem_req_data_bits, wq_d.pop_front());
              chk("wbeat_mask", 128'(mem_req_data_mask), 128'(wq_m.pop_front()));
            end
            m_cnt++;
          end
        end else begin
          chk1("no_wdata_valid", mem_req_data_valid, 1'b0);
          chk1("no_wdata_ready_ic", drdy[0], 1'b0);
          chk1("no_wdata_ready_dc", drdy[1], 1'b0);
        end
        // Request arbitration.
        if (m_busy) begin
          chk1("busy_mem_req_val", mem_req_val, 1'b0);
          chk1("busy_ic_req_rdy", rdy[0], 1'b0);
          chk1("busy_dc_req_rdy", rdy[1], 1'b0);
          if (m_cnt == 4) m_busy = 1'b0;
        end else begin
          chk1("idle_mem_req_val", mem_req_val, rv[0] | rv[1]);
          if (rv[0] | rv[1]) begin
            ew = (rv[0] & rv[1]) ? ~m_last : rv[1];
            chk("req_addr", 128'(mem_req_addr), 128'(req_addr[ew]));
            chk1("req_rw", mem_req_rw, req_rw[ew]);
            chk1("grant_winner_rdy", rdy[ew], mem_req_rdy);
            chk1("grant_loser_rdy", rdy[~ew], 1'b0);
            if (mem_req_rdy) begin
              m_busy  = 1'b1;
              m_owner = ew;
              m_last  = ew;
              m_rw    = req_rw[ew];
              m_cnt   = 0;
            end
          end
        end
      end
    end
  end

endmodule
